// File: rtl/alu_operand_pipe.sv
// alu_operand_pipe: EX-entry operand stage.
// Decodes the ALU control bundle, resolves forwarded operands from NUM_FWD
// producers (index 0 = youngest, highest priority), formats immediates for
// LW/SW, LLB/LHB and PCS, and registers {alu_a, alu_b, alu_op} into a single
// valid/ready slot. Unresolved forwarding hazards hold off acceptance and are
// counted in a saturating stall counter.
module alu_operand_pipe #(
  parameter int DATA_W  = 16,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [15:0]               instr,
  input  logic [DATA_W-1:0]         reg_data1,
  input  logic [DATA_W-1:0]         reg_data2,
  input  logic [DATA_W-1:0]         pcs,
  input  logic                      ld_byte,
  input  logic                      mem_op,
  input  logic [NUM_FWD-1:0]        fwd_hit_a,
  input  logic [NUM_FWD-1:0]        fwd_hit_b,
  input  logic [NUM_FWD-1:0]        fwd_vld,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [6:0]                alu_op,
  output logic [CNT_W-1:0]          stall_cnt
);

  // Opcode bits, named after the ABCD decode equations.
  logic op_a_s;
  logic op_b_s;
  logic op_c_s;
  logic op_d_s;

  // Decoded controls.
  logic       sat_s;
  logic       red_s;
  logic       sub_s;
  logic [1:0] outsel_s;
  logic       use_imm_s;
  logic       bytesel_s;
  logic       pcs_sel_s;
  logic [6:0] alu_op_s;

  // Forwarding resolution.
  logic              fwd_a_found_s;
  logic              fwd_a_vld_s;
  logic [DATA_W-1:0] fwd_a_data_s;
  logic              fwd_b_found_s;
  logic              fwd_b_vld_s;
  logic [DATA_W-1:0] fwd_b_data_s;

  // Operand formatting.
  logic [DATA_W-1:0] opnd_a_s;
  logic [DATA_W-1:0] imm_s;
  logic [4:0]        imm5_s;
  logic [DATA_W-1:0] reg_b_s;
  logic [DATA_W-1:0] opnd_b_s;

  // Handshake.
  logic hazard_s;
  logic slot_free_s;
  logic accept_s;
  logic stall_inc_s;

  // Registered slot.
  logic              out_valid_r;
  logic [DATA_W-1:0] alu_a_r;
  logic [DATA_W-1:0] alu_b_r;
  logic [6:0]        alu_op_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  // Register-specifier bits are consumed upstream; only the opcode, byte and
  // nibble immediates are needed here.
  logic unused_instr_s;
  assign unused_instr_s = ^instr[11:8];

  assign op_a_s = instr[15];
  assign op_b_s = instr[14];
  assign op_c_s = instr[13];
  assign op_d_s = instr[12];

  // Combinational ALU control decode from the opcode nibble.
  always_comb begin
    sat_s       = ~op_a_s & op_b_s;
    red_s       = ~op_a_s & ~op_b_s & op_c_s;
    sub_s       = ~op_a_s & ~op_b_s & op_d_s;
    outsel_s[1] = ~op_a_s & op_b_s & (~op_c_s | ~op_d_s);
    outsel_s[0] = ~op_a_s & ~op_b_s & op_c_s & op_d_s;
    use_imm_s   = (op_a_s & ~op_b_s) | (op_b_s & ~op_c_s) | (~op_a_s & op_b_s & ~op_d_s);
    // LLB (opcode 1010) takes the low-byte path, LHB (1011) the high-byte path.
    bytesel_s   = ~op_d_s;
    pcs_sel_s   = op_a_s & op_b_s;
    alu_op_s    = {outsel_s, sat_s, red_s, sub_s, instr[1:0]};
  end

  // Priority forwarding select: scan oldest to youngest so the lowest index wins.
  always_comb begin
    fwd_a_found_s = 1'b0;
    fwd_a_vld_s   = 1'b0;
    fwd_a_data_s  = reg_data1;
    fwd_b_found_s = 1'b0;
    fwd_b_vld_s   = 1'b0;
    fwd_b_data_s  = reg_data2;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_hit_a[i]) begin
        fwd_a_found_s = 1'b1;
        fwd_a_vld_s   = fwd_vld[i];
        fwd_a_data_s  = fwd_data[i*DATA_W +: DATA_W];
      end else begin
        fwd_a_found_s = fwd_a_found_s;
      end
      if (fwd_hit_b[i]) begin
        fwd_b_found_s = 1'b1;
        fwd_b_vld_s   = fwd_vld[i];
        fwd_b_data_s  = fwd_data[i*DATA_W +: DATA_W];
      end else begin
        fwd_b_found_s = fwd_b_found_s;
      end
    end
  end

  // Operand A: PCS forces zero; LLB keeps the high byte, LHB keeps the low byte.
  always_comb begin
    opnd_a_s = fwd_a_data_s;
    if (pcs_sel_s) begin
      opnd_a_s = {DATA_W{1'b0}};
    end else if (ld_byte) begin
      if (bytesel_s) begin
        opnd_a_s = {fwd_a_data_s[DATA_W-1:8], 8'h00};
      end else begin
        opnd_a_s = {{(DATA_W-8){1'b0}}, fwd_a_data_s[7:0]};
      end
    end else begin
      opnd_a_s = fwd_a_data_s;
    end
  end

  // Immediate builder: byte loads place instr[7:0], memory ops use a
  // halfword-scaled offset, everything else a sign-extended nibble.
  always_comb begin
    imm_s  = {DATA_W{1'b0}};
    imm5_s = 5'b0_0000;
    if (ld_byte) begin
      if (bytesel_s) begin
        imm_s[7:0] = instr[7:0];
      end else begin
        imm_s[15:8] = instr[7:0];
      end
    end else if (mem_op) begin
      imm5_s = {instr[3:0], 1'b0};
      imm_s  = {{(DATA_W-5){imm5_s[4]}}, imm5_s};
    end else begin
      imm_s = {{(DATA_W-4){instr[3]}}, instr[3:0]};
    end
  end

  // Operand B: PCS value, immediate, or (possibly inverted) register operand.
  always_comb begin
    reg_b_s  = fwd_b_data_s;
    opnd_b_s = fwd_b_data_s;
    if (sub_s) begin
      reg_b_s = ~fwd_b_data_s;
    end else begin
      reg_b_s = fwd_b_data_s;
    end
    if (pcs_sel_s) begin
      opnd_b_s = pcs;
    end else if (use_imm_s) begin
      opnd_b_s = imm_s;
    end else begin
      opnd_b_s = reg_b_s;
    end
  end

  // A hit on a producer without data stalls, even for an operand the op ignores.
  assign hazard_s    = in_valid & ((fwd_a_found_s & ~fwd_a_vld_s) | (fwd_b_found_s & ~fwd_b_vld_s));
  assign slot_free_s = ~out_valid_r | out_ready;
  assign in_ready    = ~rst & ~flush & ~hazard_s & slot_free_s;
  assign accept_s    = in_valid & in_ready;
  assign stall_inc_s = hazard_s & ~flush & slot_free_s;

  // Slot valid: flush clears, accept sets, consume-without-accept clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Slot payload: loads only on accept, otherwise holds (including on flush).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_r  <= {DATA_W{1'b0}};
      alu_b_r  <= {DATA_W{1'b0}};
      alu_op_r <= 7'b000_0000;
    end else if (accept_s) begin
      alu_a_r  <= opnd_a_s;
      alu_b_r  <= opnd_b_s;
      alu_op_r <= alu_op_s;
    end else begin
      alu_a_r  <= alu_a_r;
      alu_b_r  <= alu_b_r;
      alu_op_r <= alu_op_r;
    end
  end

  // Saturating count of cycles lost to forwarding hazards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign out_valid = out_valid_r;
  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_op    = alu_op_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_alu_operand_pipe.sv
// Bench for alu_operand_pipe: directed known-answer steps followed by random
// traffic, all checked against an opcode-table reference model every cycle.
module tb_alu_operand_pipe;

  localparam int DW  = 16;
  localparam int NF  = 2;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   instr;
  logic [DW-1:0] reg_data1;
  logic [DW-1:0] reg_data2;
  logic [DW-1:0] pcs;
  logic          ld_byte;
  logic          mem_op;
  logic [NF-1:0] fwd_hit_a;
  logic [NF-1:0] fwd_hit_b;
  logic [NF-1:0] fwd_vld;
  logic [NF*DW-1:0] fwd_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [6:0]    alu_op;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  // Expected slot state.
  logic          ev;
  logic [DW-1:0] ea;
  logic [DW-1:0] eb;
  logic [6:0]    eop;
  int            ecnt;

  alu_operand_pipe #(.DATA_W(DW), .NUM_FWD(NF), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .reg_data1(reg_data1), .reg_data2(reg_data2), .pcs(pcs),
    .ld_byte(ld_byte), .mem_op(mem_op), .fwd_hit_a(fwd_hit_a),
    .fwd_hit_b(fwd_hit_b), .fwd_vld(fwd_vld), .fwd_data(fwd_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: opcode classes from the decode table, forwarding by priority
  // search, immediates by plain integer arithmetic.
  task automatic model_comb(output logic [DW-1:0] a, output logic [DW-1:0] b,
                            output logic [6:0] op, output logic hz);
    int opc;
    int wa;
    int wb;
    int v;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    logic [DW-1:0] imm;
    logic sat, red, sub, os1, os0, use_imm, llb, is_pcs;
    opc = int'(instr[15:12]);
    wa = -1;
    wb = -1;
    for (int i = 0; i < NF; i++) begin
      if (wa < 0 && fwd_hit_a[i]) wa = i;
      if (wb < 0 && fwd_hit_b[i]) wb = i;
    end
    ra = (wa >= 0) ? fwd_data[wa*DW +: DW] : reg_data1;
    rb = (wb >= 0) ? fwd_data[wb*DW +: DW] : reg_data2;
    hz = in_valid && ((wa >= 0 && !fwd_vld[wa]) || (wb >= 0 && !fwd_vld[wb]));
    sat     = opc inside {4, 5, 6, 7};
    red     = opc inside {2, 3};
    sub     = opc inside {1, 3};
    os1     = opc inside {4, 5, 6};
    os0     = (opc == 3);
    use_imm = opc inside {4, 5, 6, 8, 9, 10, 11, 12, 13};
    is_pcs  = opc >= 12;
    llb     = (opc % 2) == 0;
    op = {os1, os0, sat, red, sub, instr[1:0]};
    if (ld_byte) begin
      imm = llb ? {8'h00, instr[7:0]} : {instr[7:0], 8'h00};
    end else begin
      v = int'(instr[3:0]);
      if (v >= 8) v = v - 16;
      if (mem_op) v = v * 2;
      imm = DW'(v);
    end
    if (is_pcs) a = '0;
    else if (ld_byte) a = llb ? (ra & 16'hFF00) : (ra & 16'h00FF);
    else a = ra;
    if (is_pcs) b = pcs;
    else if (use_imm) b = imm;
    else b = sub ? ~rb : rb;
  endtask

  task automatic check_outs();
    chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
    chk("alu_a", {16'd0, alu_a}, {16'd0, ea});
    chk("alu_b", {16'd0, alu_b}, {16'd0, eb});
    chk("alu_op", {25'd0, alu_op}, {25'd0, eop});
    chk("stall_cnt", {28'd0, stall_cnt}, 32'(ecnt));
  endtask

  // One clock: check in_ready before the edge, advance the model, check after.
  task automatic step();
    logic [DW-1:0] ma;
    logic [DW-1:0] mb;
    logic [6:0] mop;
    logic mhz;
    logic erdy;
    #1;
    model_comb(ma, mb, mop, mhz);
    erdy = !flush && !mhz && (!ev || out_ready);
    chk("in_ready", {31'd0, in_ready}, {31'd0, erdy});
    @(posedge clk);
    if (mhz && !flush && (!ev || out_ready) && ecnt != 15) ecnt++;
    if (flush) ev = 1'b0;
    else if (in_valid && erdy) begin
      ev = 1'b1; ea = ma; eb = mb; eop = mop;
    end else if (out_ready) ev = 1'b0;
    #1;
    check_outs();
  endtask

  task automatic idle();
    in_valid = 1'b0; instr = 16'h0000; reg_data1 = 16'h0000; reg_data2 = 16'h0000;
    pcs = 16'h0000; ld_byte = 1'b0; mem_op = 1'b0; fwd_hit_a = 2'b00;
    fwd_hit_b = 2'b00; fwd_vld = 2'b00; fwd_data = 32'h0; flush = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b1; in_valid = 1'b1;
    ev = 1'b0; ea = '0; eb = '0; eop = '0; ecnt = 0;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_outs();
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    step();

    // ADD, register operands.
    in_valid = 1'b1; instr = 16'h0123; reg_data1 = 16'd5; reg_data2 = 16'd7;
    step();
    chk("add_a", {16'd0, alu_a}, 32'd5);
    chk("add_b", {16'd0, alu_b}, 32'd7);
    chk("add_v", {31'd0, out_valid}, 32'd1);

    // SUB, both sources hit B; source 0 wins and is inverted.
    instr = 16'h1123; fwd_hit_b = 2'b11; fwd_vld = 2'b11; fwd_data = {16'd9, 16'd3};
    step();
    chk("sub_b", {16'd0, alu_b}, 32'h0000_FFFC);
    chk("sub_bit", {31'd0, alu_op[2]}, 32'd1);

    // Forwarding hazard on A for three cycles, then resolved.
    instr = 16'h0123; fwd_hit_b = 2'b00; fwd_hit_a = 2'b01; fwd_vld = 2'b00;
    fwd_data = {16'h0000, 16'h1234};
    repeat (3) step();
    chk("stall3", {28'd0, stall_cnt}, 32'd3);
    fwd_vld = 2'b01;
    step();
    chk("fwd_a", {16'd0, alu_a}, 32'h0000_1234);

    // Backpressure: outputs hold, then back-to-back transfer.
    fwd_hit_a = 2'b00; out_ready = 1'b0; reg_data1 = 16'h0011;
    repeat (2) step();
    chk("bp_hold_a", {16'd0, alu_a}, 32'h0000_1234);
    out_ready = 1'b1;
    step();
    chk("b2b_a0", {16'd0, alu_a}, 32'h0000_0011);
    reg_data1 = 16'h0022;
    step();
    chk("b2b_a1", {16'd0, alu_a}, 32'h0000_0022);
    chk("b2b_v", {31'd0, out_valid}, 32'd1);

    // LW offset scaling, LLB formatting.
    instr = 16'h8125; mem_op = 1'b1;
    step();
    chk("lw_b", {16'd0, alu_b}, 32'h0000_000A);
    instr = 16'hA1F0; mem_op = 1'b0; ld_byte = 1'b1; reg_data1 = 16'hABCD;
    step();
    chk("llb_a", {16'd0, alu_a}, 32'h0000_AB00);
    chk("llb_b", {16'd0, alu_b}, 32'h0000_00F0);

    // PCS, then flush with a valid bundle held.
    instr = 16'hE100; ld_byte = 1'b0; pcs = 16'h0042;
    step();
    chk("pcs_a", {16'd0, alu_a}, 32'd0);
    chk("pcs_b", {16'd0, alu_b}, 32'h0000_0042);
    flush = 1'b1;
    step();
    chk("flush_v", {31'd0, out_valid}, 32'd0);
    chk("flush_b", {16'd0, alu_b}, 32'h0000_0042);

    // Long stall drives the counter into saturation.
    flush = 1'b0; instr = 16'h0123; fwd_hit_a = 2'b01; fwd_vld = 2'b00;
    repeat (16) step();
    chk("sat", {28'd0, stall_cnt}, 32'd15);

    // Asynchronous reset in the middle of a stall.
    #2 rst = 1'b1;
    #1;
    ev = 1'b0; ea = '0; eb = '0; eop = '0; ecnt = 0;
    chk("arst_rdy", {31'd0, in_ready}, 32'd0);
    check_outs();
    @(posedge clk); #1;
    rst = 1'b0; fwd_hit_a = 2'b00;
    step();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      instr     = 16'($urandom);
      reg_data1 = 16'($urandom);
      reg_data2 = 16'($urandom);
      pcs       = 16'($urandom);
      ld_byte   = ($urandom_range(0, 3) == 0);
      mem_op    = ($urandom_range(0, 3) == 0);
      fwd_hit_a = 2'($urandom);
      fwd_hit_b = 2'($urandom);
      fwd_vld   = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      fwd_data  = $urandom;
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
